axi_llc_sram_arb: RTL and testbench

//  Shares one axi_llc_sram port between NumReq requesters (e.g. tag lookup, refill, evict, scrub unit).

---
 rtl/axi_llc_pkg.sv | 11 +
 rtl/axi_llc_sram_rsp_pipe.sv | 41 ++++
 rtl/axi_llc_sram_arb.sv | 148 ++++++++++++++
 tb/tb_axi_llc_sram_arb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_llc_pkg.sv
// Shared constants for the LLC SRAM arbiter: FSM encodings and the index-width helper.
package axi_llc_pkg;

   localparam logic [0:0] ARB_IDLE   = 1'b0;
   localparam logic [0:0] ARB_LOCKED = 1'b1;

   function automatic int unsigned idx_width(input int unsigned num);
      return (num > 1) ? $clog2(num) : 1;
   endfunction

endpackage

// File: rtl/axi_llc_sram_rsp_pipe.sv
// Read-response tracker: Latency-deep {valid,idx} shift register that raises a one-hot
// rvalid exactly Latency cycles after each read handshake.
module axi_llc_sram_rsp_pipe #(
   parameter int unsigned NumReq   = 2,
   parameter int unsigned IdxWidth = 1,
   parameter int unsigned Latency  = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                push_i,
   input  logic [IdxWidth-1:0] idx_i,
   output logic [NumReq-1:0]   rvalid_o
);

   typedef struct packed {
      logic                valid;
      logic [IdxWidth-1:0] idx;
   } rsp_t;

   rsp_t pipe_q [Latency];
   rsp_t tail;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < Latency; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= '{valid: push_i, idx: idx_i};
         for (int i = 1; i < Latency; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tail = pipe_q[Latency-1];

   always_comb begin
      rvalid_o = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (tail.valid && (tail.idx == IdxWidth'(i))) rvalid_o[i] = 1'b1;
      end
   end

endmodule

// File: rtl/axi_llc_sram_arb.sv
// Round-robin arbiter sharing one LLC SRAM port; locks the chosen requester while the SRAM
// withholds its grant. Define AXI_LLC_SRAM_ARB_FIXED_PRIO_EN to give requester 0 absolute priority.
module axi_llc_sram_arb
   import axi_llc_pkg::*;
#(
   parameter int unsigned NumReq    = 2,
   parameter int unsigned AddrWidth = 10,
   parameter int unsigned DataWidth = 128,
   parameter int unsigned BeWidth   = 16,
   parameter int unsigned Latency   = 1,
   parameter int unsigned IdxWidth  = idx_width(NumReq)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumReq-1:0]             req_i,
   input  logic [NumReq-1:0]             we_i,
   input  logic [NumReq*AddrWidth-1:0]   addr_i,
   input  logic [NumReq*DataWidth-1:0]   wdata_i,
   input  logic [NumReq*BeWidth-1:0]     be_i,
   output logic [NumReq-1:0]             gnt_o,
   output logic [NumReq-1:0]             rvalid_o,
   output logic [DataWidth-1:0]          rdata_o,
   output logic                          sram_req_o,
   output logic                          sram_we_o,
   output logic [AddrWidth-1:0]          sram_addr_o,
   output logic [DataWidth-1:0]          sram_wdata_o,
   output logic [BeWidth-1:0]            sram_be_o,
   input  logic                          sram_gnt_i,
   input  logic [DataWidth-1:0]          sram_rdata_i,
   output logic                          dbg_state_o,
   output logic [IdxWidth-1:0]           dbg_ptr_o
);

   typedef logic [IdxWidth-1:0] idx_t;

   // Handshake: a transfer happens in any cycle where req_i[i] & gnt_o[i]; the SRAM side
   // transfers on sram_req_o & sram_gnt_i, which is the same event.
   logic [0:0]          state_q, state_d;
   idx_t                ptr_q, ptr_d;
   idx_t                lock_q, lock_d;
   idx_t                arb_sel, sel;
   logic [NumReq-1:0]   rr_req;
   logic [IdxWidth:0]   cand;
   logic                rr_found;
   logic                any_req;
   logic                hs;

   function automatic idx_t next_idx(input idx_t cur);
      return (32'(cur) >= NumReq - 1) ? '0 : cur + 1'b1;
   endfunction

   // First requesting index at or after the pointer, wrapping at NumReq.
   always_comb begin
      rr_req = req_i;
`ifdef AXI_LLC_SRAM_ARB_FIXED_PRIO_EN
      rr_req[0] = 1'b0;
`endif
      rr_found = 1'b0;
      arb_sel  = ptr_q;
      cand     = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         cand = {1'b0, ptr_q} + (IdxWidth+1)'(k);
         if (cand >= (IdxWidth+1)'(NumReq)) cand = cand - (IdxWidth+1)'(NumReq);
         if (!rr_found && rr_req[cand[IdxWidth-1:0]]) begin
            rr_found = 1'b1;
            arb_sel  = cand[IdxWidth-1:0];
         end
      end
`ifdef AXI_LLC_SRAM_ARB_FIXED_PRIO_EN
      if (req_i[0]) arb_sel = '0;
`endif
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      any_req = |req_i;
      if (state_q == ARB_LOCKED) begin
         sel        = lock_q;
         sram_req_o = req_i[lock_q];
      end else begin
         sel        = arb_sel;
         sram_req_o = any_req;
      end
      hs    = sram_req_o & sram_gnt_i;
      gnt_o = '0;
      if (hs) gnt_o[sel] = 1'b1;

      sram_we_o    = we_i[sel];
      sram_addr_o  = addr_i[32'(sel)*AddrWidth +: AddrWidth];
      sram_wdata_o = wdata_i[32'(sel)*DataWidth +: DataWidth];
      sram_be_o    = be_i[32'(sel)*BeWidth +: BeWidth];

      case (state_q)
         ARB_IDLE: begin
            if (hs) begin
               ptr_d = next_idx(sel);
            end else if (any_req) begin
               state_d = ARB_LOCKED;
               lock_d  = sel;
            end
         end
         ARB_LOCKED: begin
            // A dropped request is illegal; falling back to IDLE keeps the port from wedging.
            if (hs || !req_i[lock_q]) begin
               state_d = ARB_IDLE;
               if (hs) ptr_d = next_idx(lock_q);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
      end
   end

   axi_llc_sram_rsp_pipe #(
      .NumReq   (NumReq),
      .IdxWidth (IdxWidth),
      .Latency  (Latency)
   ) u_rsp_pipe (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_i   (hs & ~sram_we_o),
      .idx_i    (sel),
      .rvalid_o (rvalid_o)
   );

   assign rdata_o     = sram_rdata_i;
   assign dbg_state_o = state_q[0];
   assign dbg_ptr_o   = ptr_q;

`ifndef SYNTHESIS
   lock_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == ARB_LOCKED) |-> req_i[lock_q]);
`endif

endmodule

// File: tb/tb_axi_llc_sram_arb.sv
// Directed bench for axi_llc_sram_arb: three instances (2 req/lat 1, 2 req/lat 3, 3 req/lat 1).
module tb_axi_llc_sram_arb;

   localparam int AW = 10;
   localparam int DW = 128;
   localparam int BW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Instance A: NumReq=2, Latency=1, with SRAM model
   logic [1:0]      a_req, a_we, a_gnt, a_rvalid;
   logic [2*AW-1:0] a_addr;
   logic [2*DW-1:0] a_wdata;
   logic [2*BW-1:0] a_be;
   logic [DW-1:0]   a_rdata, a_sram_wdata, a_sram_rdata;
   logic            a_sram_req, a_sram_we, a_sram_gnt, a_state;
   logic [AW-1:0]   a_sram_addr;
   logic [BW-1:0]   a_sram_be;
   logic [0:0]      a_ptr;

   // Instance B: NumReq=2, Latency=3
   logic [1:0]      b_req, b_gnt, b_rvalid;
   logic [DW-1:0]   b_rdata, b_sram_wdata;
   logic            b_sram_req, b_sram_we, b_state;
   logic [AW-1:0]   b_sram_addr;
   logic [BW-1:0]   b_sram_be;
   logic [0:0]      b_ptr;

   // Instance C: NumReq=3, Latency=1
   logic [2:0]      c_req, c_gnt, c_rvalid;
   logic [DW-1:0]   c_rdata, c_sram_wdata;
   logic            c_sram_req, c_sram_we, c_state;
   logic [AW-1:0]   c_sram_addr;
   logic [BW-1:0]   c_sram_be;
   logic [1:0]      c_ptr;

   axi_llc_sram_arb #(.NumReq(2), .Latency(1)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
      .wdata_i(a_wdata), .be_i(a_be), .gnt_o(a_gnt), .rvalid_o(a_rvalid), .rdata_o(a_rdata),
      .sram_req_o(a_sram_req), .sram_we_o(a_sram_we), .sram_addr_o(a_sram_addr),
      .sram_wdata_o(a_sram_wdata), .sram_be_o(a_sram_be), .sram_gnt_i(a_sram_gnt),
      .sram_rdata_i(a_sram_rdata), .dbg_state_o(a_state), .dbg_ptr_o(a_ptr)
   );

   axi_llc_sram_arb #(.NumReq(2), .Latency(3)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .req_i(b_req), .we_i(2'b00), .addr_i('0),
      .wdata_i('0), .be_i('0), .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata),
      .sram_req_o(b_sram_req), .sram_we_o(b_sram_we), .sram_addr_o(b_sram_addr),
      .sram_wdata_o(b_sram_wdata), .sram_be_o(b_sram_be), .sram_gnt_i(1'b1),
      .sram_rdata_i('0), .dbg_state_o(b_state), .dbg_ptr_o(b_ptr)
   );

   axi_llc_sram_arb #(.NumReq(3), .Latency(1)) u_dut_c (
      .clk_i(clk), .rst_i(rst), .req_i(c_req), .we_i(3'b000), .addr_i('0),
      .wdata_i('0), .be_i('0), .gnt_o(c_gnt), .rvalid_o(c_rvalid), .rdata_o(c_rdata),
      .sram_req_o(c_sram_req), .sram_we_o(c_sram_we), .sram_addr_o(c_sram_addr),
      .sram_wdata_o(c_sram_wdata), .sram_be_o(c_sram_be), .sram_gnt_i(1'b1),
      .sram_rdata_i('0), .dbg_state_o(c_state), .dbg_ptr_o(c_ptr)
   );

   // Latency-1 SRAM model for instance A
   logic [DW-1:0] mem_a [16];
   always @(posedge clk) begin
      if (a_sram_req && a_sram_gnt) begin
         if (a_sram_we) begin
            for (int b = 0; b < BW; b++)
               if (a_sram_be[b]) mem_a[a_sram_addr[3:0]][8*b +: 8] <= a_sram_wdata[8*b +: 8];
         end else begin
            a_sram_rdata <= mem_a[a_sram_addr[3:0]];
         end
      end
   end

   logic [1:0] t4_gnt [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
   logic [1:0] t4_rv  [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
`ifdef AXI_LLC_SRAM_ARB_FIXED_PRIO_EN
   logic [2:0] t6_all [4] = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
   logic [2:0] t6_all [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
   logic [2:0] t6_no0 [4] = '{3'b010, 3'b100, 3'b010, 3'b100};

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_be = '0; a_sram_gnt = 1'b1;
      b_req = '0; c_req = '0;
      a_sram_rdata = '0;
      for (int i = 0; i < 16; i++) mem_a[i] = {4{32'hC0DE_0000 + 32'(i)}};
      mem_a[3] = {4{32'h1111_0003}};
      repeat (2) next_cycle();
      rst = 1'b0; #1;
      chk("rst_gnt", a_gnt, 0);
      chk("rst_rvalid", a_rvalid, 0);
      chk("rst_sram_req", a_sram_req, 0);
      chk("rst_state", a_state, 0);
      chk("rst_ptr", a_ptr, 0);
      chk("rst_b_rvalid", b_rvalid, 0);

      // Two simultaneous reads, round-robin order 0 then 1
      next_cycle(); a_req = 2'b11; a_addr = {10'd9, 10'd5}; #1;
      chk("t1_gnt0", a_gnt, 2'b01);
      chk("t1_addr0", a_sram_addr, 10'd5);
      next_cycle(); a_req = 2'b10; #1;
      chk("t1_gnt1", a_gnt, 2'b10);
      chk("t1_addr1", a_sram_addr, 10'd9);
      chk("t1_rv0", a_rvalid, 2'b01);
      chk("t1_rd0", a_rdata, {4{32'hC0DE_0005}});
      next_cycle(); a_req = 2'b00; #1;
      chk("t1_rv1", a_rvalid, 2'b10);
      chk("t1_rd1", a_rdata, {4{32'hC0DE_0009}});
      chk("t1_idle", a_sram_req, 0);

      // SRAM grant withheld for 3 cycles: requester 0 locked, requester 1 waits
      next_cycle(); a_req = 2'b01; a_addr = {10'd12, 10'd7}; a_sram_gnt = 1'b0; #1;
      chk("t2_sram_req", a_sram_req, 1);
      chk("t2_gnt_wait", a_gnt, 2'b00);
      chk("t2_addr", a_sram_addr, 10'd7);
      for (int k = 0; k < 2; k++) begin
         next_cycle(); a_req = 2'b11; #1;
         chk("t2_lock_addr", a_sram_addr, 10'd7);
         chk("t2_lock_gnt", a_gnt, 2'b00);
         chk("t2_lock_state", a_state, 1);
      end
      next_cycle(); a_sram_gnt = 1'b1; #1;
      chk("t2_gnt0", a_gnt, 2'b01);
      chk("t2_addr0", a_sram_addr, 10'd7);
      next_cycle(); a_req = 2'b10; #1;
      chk("t2_gnt1", a_gnt, 2'b10);
      chk("t2_addr1", a_sram_addr, 10'd12);
      chk("t2_rv0", a_rvalid, 2'b01);
      chk("t2_rd0", a_rdata, {4{32'hC0DE_0007}});
      chk("t2_unlock", a_state, 0);
      next_cycle(); a_req = 2'b00; #1;
      chk("t2_rv1", a_rvalid, 2'b10);
      chk("t2_rd1", a_rdata, {4{32'hC0DE_000C}});

      // Partial write from requester 1, read back by requester 0
      next_cycle();
      a_req = 2'b10; a_we = 2'b10; a_addr = {10'd3, 10'd0};
      a_wdata = {{16{8'hA5}}, 128'h0}; a_be = {16'h00FF, 16'h0000}; #1;
      chk("t3_wgnt", a_gnt, 2'b10);
      chk("t3_we", a_sram_we, 1);
      chk("t3_be", a_sram_be, 16'h00FF);
      chk("t3_wdata", a_sram_wdata, {16{8'hA5}});
      next_cycle(); a_req = 2'b01; a_we = 2'b00; a_addr = {10'd0, 10'd3}; #1;
      chk("t3_rgnt", a_gnt, 2'b01);
      chk("t3_no_wr_rvalid", a_rvalid, 2'b00);
      next_cycle(); a_req = 2'b00; #1;
      chk("t3_rv", a_rvalid, 2'b01);
      chk("t3_rd", a_rdata, {64'h1111_0003_1111_0003, 64'hA5A5_A5A5_A5A5_A5A5});

      // Latency 3, back-to-back alternating reads
      for (int k = 0; k < 8; k++) begin
         next_cycle(); b_req = (k < 4) ? 2'b11 : 2'b00; #1;
         chk($sformatf("t4_gnt%0d", k), b_gnt, t4_gnt[k]);
         chk($sformatf("t4_rv%0d", k), b_rvalid, t4_rv[k]);
      end

      // Three requesters, all then without requester 0
      for (int k = 0; k < 4; k++) begin
         next_cycle(); c_req = 3'b111; #1;
         chk($sformatf("t6_all%0d", k), c_gnt, t6_all[k]);
      end
      for (int k = 0; k < 4; k++) begin
         next_cycle(); c_req = 3'b110; #1;
         chk($sformatf("t6_no0_%0d", k), c_gnt, t6_no0[k]);
      end
      next_cycle(); c_req = 3'b000;

      // Reset with reads in flight on B and A held in LOCKED
      next_cycle(); b_req = 2'b11; a_req = 2'b01; a_addr = {10'd0, 10'd5}; a_sram_gnt = 1'b0; #1;
      chk("t5_gnt_a", b_gnt, 2'b01);
      next_cycle(); #1;
      chk("t5_gnt_b", b_gnt, 2'b10);
      chk("t5_a_locked", a_state, 1);
      next_cycle(); #1;
      chk("t5_gnt_c", b_gnt, 2'b01);
      next_cycle(); rst = 1'b1; b_req = 2'b00; a_req = 2'b00; #1;
      chk("t5_pre_ptr", b_ptr, 1);
      chk("t5_pre_rv", b_rvalid, 2'b01);
      next_cycle(); rst = 1'b0; a_sram_gnt = 1'b1; #1;
      chk("t5_ptr", b_ptr, 0);
      chk("t5_a_state", a_state, 0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t5_rv%0d", k), b_rvalid, 2'b00);
         next_cycle(); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
